udpy_sweep_checker: RTL and testbench
=====================================

Name: udpy_sweep_checker

Overview:
- Sequential stimulus-and-capture stage wrapped around the udpY combinational primitive, which implements Y = AB'D + BCD' + AC.
- Drives the primitive's A, B, C, D inputs through all 16 input combinations. After a programmable settle time, samples the returned Y for each combination.
- Assembles the measured 16-entry truth table and compares it against an expected table. Reports done, pass, mismatch count and first failing index.
- Used as the on-chip self-check for udpY and for any replacement implementation of the same function.

Parameters:
- SETTLE_CYCLES, 2: number of extra cycles each vector is held before Y is sampled. Legal range 0..15.
- EXPECTED, 16'hCE40: expected truth table. Bit i is the Y value for {A,B,C,D} = i. Default is the udpY function, which is 1 at indices 6, 9, 10, 11, 14 and 15.

Ports:
- clk, input, 1: single clock; everything updates on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- start, input, 1: sweep request; honoured only in IDLE.
- a_out, output, 1: drives udpY input A; it is the MSB of the current index.
- b_out, output, 1: drives udpY input B.
- c_out, output, 1: drives udpY input C.
- d_out, output, 1: drives udpY input D; it is the LSB of the current index.
- y_in, input, 1: Y returned from udpY.
- busy, output, 1: high from the start edge until the DONE cycle, exclusive of DONE.
- done, output, 1: single-cycle pulse when the sweep completes.
- pass, output, 1: 1 when the measured table equals EXPECTED. Valid from done until the next accepted start.
- truth_table, output, 16: measured table; bit i holds the Y sampled at index i.
- mismatch_cnt, output, 5: number of indices where the sample differs from EXPECTED (0..16).
- first_fail_idx, output, 4: lowest failing index.
- first_fail_valid, output, 1: first_fail_idx holds a real failing index.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, index=0, settle counter=0. All outputs are 0: a_out..d_out, busy, done, pass, truth_table, mismatch_cnt, first_fail_idx, first_fail_valid. Reset mid-sweep aborts the sweep; no done pulse is generated.
- State machine has four states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 → SETTLE. On the same edge: index=0, counter=SETTLE_CYCLES, and truth_table, mismatch_cnt, pass, first_fail_valid and first_fail_idx are all cleared.
  - busy=1 from the next cycle.
- SETTLE:
  - {a_out,b_out,c_out,d_out} = index, driven from registers.
  - counter≠0 → decrement. counter==0 → SAMPLE.
- SAMPLE:
  - truth_table[index] <= y_in.
  - If y_in ≠ EXPECTED[index]: mismatch_cnt++. If first_fail_valid=0, also set first_fail_idx=index and first_fail_valid=1.
  - index==15 → DONE. Otherwise index++, counter=SETTLE_CYCLES, → SETTLE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - pass=1 iff the mismatch count including the final sample is 0. Compute it combinationally from the next-state count so that pass is valid in the DONE cycle.
  - DONE → IDLE unconditionally.
- Timing: each vector takes SETTLE_CYCLES+2 edges. If start is accepted at edge k, done is high in the cycle after edge k+16*(SETTLE_CYCLES+2). With the default, that is edge k+64.
- Vector outputs hold index 15 after the sweep and return to 0 on the next accepted start.
- start while busy or in DONE: ignored, with no restart and no effect on the results.
- Results (pass, truth_table, mismatch_cnt, first_fail_*) hold after done until the next accepted start or reset.
- mismatch_cnt saturates naturally at 16. No wrap is possible with 16 vectors in 5 bits.
- Inputs are sampled only in SAMPLE. y_in glitches during SETTLE are ignored.

Test Plan:
- Golden udpY connected, start pulse → outputs step through indices 0..15, each held 4 cycles. done at start+64 with truth_table=16'hCE40, pass=1, mismatch_cnt=0, first_fail_valid=0.
- y_in tied 0 → truth_table=16'h0000, mismatch_cnt=6, first_fail_idx=6, first_fail_valid=1, pass=0.
- Model that inverts Y only at index 9 ({A,B,C,D}=1001) → truth_table=16'hCC40, mismatch_cnt=1, first_fail_idx=9, pass=0.
- start held high through the whole sweep and pulsed again in the DONE cycle → only one sweep runs. A start one cycle after DONE is accepted and clears the previous results.
- rst asserted while index=5 → next cycle all outputs are 0 and the state is IDLE, with no done pulse. A fresh start then completes normally with pass=1.
- SETTLE_CYCLES=0 with golden udpY → 2 cycles per vector, done at start+32, truth_table=16'hCE40, pass=1.

Source files
------------

// File: rtl/udpy_sweep_checker.sv
// Sweeps the udpY primitive through all 16 {A,B,C,D} combinations, captures Y
// after a settle delay and grades the measured truth table against EXPECTED.
module udpy_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = 16'hCE40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        a_out,
  output logic        b_out,
  output logic        c_out,
  output logic        d_out,
  input  logic        y_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] truth_table,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail_idx,
  output logic        first_fail_valid
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  index_q, index_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tt_q, tt_d;
  logic [4:0]  mc_q, mc_d;
  logic [3:0]  ffi_q, ffi_d;
  logic        ffv_q, ffv_d;
  logic        pass_q, pass_d;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    cnt_d   = cnt_q;
    tt_d    = tt_q;
    mc_d    = mc_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          index_d = 4'd0;
          cnt_d   = SETTLE_INIT;
          tt_d    = 16'd0;
          mc_d    = 5'd0;
          ffi_d   = 4'd0;
          ffv_d   = 1'b0;
          pass_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = SAMPLE;
      end
      SAMPLE: begin
        tt_d[index_q] = y_in;
        if (y_in != EXPECTED[index_q]) begin
          mc_d = mc_q + 5'd1;
          if (!ffv_q) begin
            ffi_d = index_q;
            ffv_d = 1'b1;
          end
        end
        // pass uses the updated count so it is already valid in the DONE cycle
        if (index_q == 4'd15) begin
          state_d = DONE;
          pass_d  = (mc_d == 5'd0);
        end else begin
          index_d = index_q + 4'd1;
          cnt_d   = SETTLE_INIT;
          state_d = SETTLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= 4'd0;
      cnt_q   <= 4'd0;
      tt_q    <= 16'd0;
      mc_q    <= 5'd0;
      ffi_q   <= 4'd0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      tt_q    <= tt_d;
      mc_q    <= mc_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
    end
  end

  assign {a_out, b_out, c_out, d_out} = index_q;
  assign busy             = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done             = (state_q == DONE);
  assign pass             = pass_q;
  assign truth_table      = tt_q;
  assign mismatch_cnt     = mc_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_udpy_sweep_checker.sv
// Scoreboarded bench for udpy_sweep_checker: a behavioural udpY (golden or faulty)
// feeds each checker instance; predicted sweep results are queued at start.
module tb_udpy_sweep_checker;

  localparam logic [15:0] GOLD_TT = 16'hCE40;

  typedef struct {
    logic [15:0] tt;
    logic [4:0]  mc;
    logic [3:0]  ffi;
    logic        ffv;
    logic        pass;
    int          edges;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start2 = 1'b0, start0 = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       sel0 = 1'b0;

  logic a2, b2, c2, d2, y2, busy2, done2, pass2, ffv2;
  logic [15:0] tt2; logic [4:0] mc2; logic [3:0] ffi2;
  logic a0, b0, c0, d0, y0, busy0, done0, pass0, ffv0;
  logic [15:0] tt0; logic [4:0] mc0; logic [3:0] ffi0;

  // mode 0 = golden udpY, 1 = Y stuck at 0, 2 = golden with index 9 inverted
  function automatic logic ref_y(input logic [1:0] m, input logic [3:0] idx);
    logic a, b, c, d, g;
    {a, b, c, d} = idx;
    g = (a & ~b & d) | (b & c & ~d) | (a & c);
    case (m)
      2'd0:    return g;
      2'd1:    return 1'b0;
      default: return g ^ (idx == 4'd9);
    endcase
  endfunction

  assign y2 = ref_y(mode, {a2, b2, c2, d2});
  assign y0 = ref_y(mode, {a0, b0, c0, d0});

  udpy_sweep_checker #(.SETTLE_CYCLES(2), .EXPECTED(16'hCE40)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .a_out(a2), .b_out(b2), .c_out(c2), .d_out(d2), .y_in(y2),
    .busy(busy2), .done(done2), .pass(pass2), .truth_table(tt2),
    .mismatch_cnt(mc2), .first_fail_idx(ffi2), .first_fail_valid(ffv2)
  );

  udpy_sweep_checker #(.SETTLE_CYCLES(0), .EXPECTED(16'hCE40)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .a_out(a0), .b_out(b0), .c_out(c0), .d_out(d0), .y_in(y0),
    .busy(busy0), .done(done0), .pass(pass0), .truth_table(tt0),
    .mismatch_cnt(mc0), .first_fail_idx(ffi0), .first_fail_valid(ffv0)
  );

  logic        o_busy, o_done, o_pass, o_ffv;
  logic [15:0] o_tt;
  logic [4:0]  o_mc;
  logic [3:0]  o_ffi, o_vec;
  always_comb begin
    o_busy = sel0 ? busy0 : busy2;
    o_done = sel0 ? done0 : done2;
    o_pass = sel0 ? pass0 : pass2;
    o_ffv  = sel0 ? ffv0  : ffv2;
    o_tt   = sel0 ? tt0   : tt2;
    o_mc   = sel0 ? mc0   : mc2;
    o_ffi  = sel0 ? ffi0  : ffi2;
    o_vec  = sel0 ? {a0, b0, c0, d0} : {a2, b2, c2, d2};
  end

  function automatic exp_t predict(input logic [1:0] m, input int settle);
    exp_t e;
    logic y;
    e.tt = '0; e.mc = '0; e.ffi = '0; e.ffv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      y = ref_y(m, 4'(i));
      e.tt[i] = y;
      if (y != GOLD_TT[i]) begin
        e.mc = e.mc + 5'd1;
        if (!e.ffv) begin
          e.ffi = 4'(i);
          e.ffv = 1'b1;
        end
      end
    end
    e.pass  = (e.mc == 5'd0);
    e.edges = 16 * (settle + 2);
    return e;
  endfunction

  // Called at a negedge; start is accepted on the following posedge.
  task automatic start_sweep(input bit hold);
    sb.push_back(predict(mode, sel0 ? 0 : 2));
    if (sel0) start0 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      start0 = 1'b0;
      start2 = 1'b0;
    end
  endtask

  // Steps negedges until done, recording edges since acceptance and any
  // index that was not held for exactly settle+2 busy cycles or went backwards.
  task automatic wait_done(input int init_cyc, output int edges, output int hold_bad);
    int hold_cnt[16];
    int cyc;
    int settle;
    int prev;
    settle = sel0 ? 0 : 2;
    cyc = init_cyc;
    hold_bad = 0;
    prev = 0;
    for (int i = 0; i < 16; i++) hold_cnt[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (o_busy) begin
        hold_cnt[o_vec]++;
        if (int'(o_vec) < prev) hold_bad++;
        prev = int'(o_vec);
      end
      if (o_done) break;
      if (cyc > 200) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL done_timeout: got no done after %0d cycles, want done", cyc);
        break;
      end
    end
    for (int i = 0; i < 16; i++)
      if (init_cyc == 0 && hold_cnt[i] != settle + 2) hold_bad++;
    edges = cyc - 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({a2, b2, c2, d2, busy2, done2, pass2, tt2, mc2, ffi2, ffv2} !== 33'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_dut2: got %h, want 0",
               {a2, b2, c2, d2, busy2, done2, pass2, tt2, mc2, ffi2, ffv2});
    end
    vectors++;
    if ({a0, b0, c0, d0, busy0, done0, pass0, tt0, mc0, ffi0, ffv0} !== 33'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_dut0: got %h, want 0",
               {a0, b0, c0, d0, busy0, done0, pass0, tt0, mc0, ffi0, ffv0});
    end
    rst = 1'b0;
  endtask

  task automatic test_golden();
    exp_t e;
    int edges, hold_bad;
    sel0 = 1'b0; mode = 2'd0;
    start_sweep(1'b0);
    wait_done(0, edges, hold_bad);
    e = sb.pop_front();
    vectors++; if (edges != e.edges) begin miscompares++; $display("[TB] FAIL golden_latency: got %0d, want %0d", edges, e.edges); end
    vectors++; if (hold_bad != 0) begin miscompares++; $display("[TB] FAIL golden_vector_hold: got %0d bad, want 0", hold_bad); end
    vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL golden_busy_in_done: got %b, want 0", o_busy); end
    vectors++; if (o_tt !== e.tt) begin miscompares++; $display("[TB] FAIL golden_tt: got %h, want %h", o_tt, e.tt); end
    vectors++; if (o_tt !== 16'hCE40) begin miscompares++; $display("[TB] FAIL golden_tt_const: got %h, want ce40", o_tt); end
    vectors++; if ({o_pass, o_mc, o_ffv} !== {e.pass, e.mc, e.ffv}) begin miscompares++; $display("[TB] FAIL golden_grade: got %b/%0d/%b, want %b/%0d/%b", o_pass, o_mc, o_ffv, e.pass, e.mc, e.ffv); end
    @(negedge clk);
    vectors++; if (o_done !== 1'b0) begin miscompares++; $display("[TB] FAIL golden_done_pulse: got %b, want 0", o_done); end
    vectors++; if ({o_vec, o_pass, o_tt} !== {4'd15, 1'b1, e.tt}) begin miscompares++; $display("[TB] FAIL golden_hold_after: got %h, want %h", {o_vec, o_pass, o_tt}, {4'd15, 1'b1, e.tt}); end
  endtask

  task automatic test_tied_zero();
    exp_t e;
    int edges, hold_bad;
    sel0 = 1'b0; mode = 2'd1;
    start_sweep(1'b0);
    wait_done(0, edges, hold_bad);
    e = sb.pop_front();
    vectors++; if (o_tt !== e.tt) begin miscompares++; $display("[TB] FAIL zero_tt: got %h, want %h", o_tt, e.tt); end
    vectors++; if (o_mc !== 5'd6) begin miscompares++; $display("[TB] FAIL zero_mc: got %0d, want 6", o_mc); end
    vectors++; if ({o_ffv, o_ffi} !== {e.ffv, e.ffi}) begin miscompares++; $display("[TB] FAIL zero_first_fail: got %b/%0d, want %b/%0d", o_ffv, o_ffi, e.ffv, e.ffi); end
    vectors++; if (o_pass !== e.pass) begin miscompares++; $display("[TB] FAIL zero_pass: got %b, want %b", o_pass, e.pass); end
    @(negedge clk);
  endtask

  task automatic test_single_fault();
    exp_t e;
    int edges, hold_bad;
    sel0 = 1'b0; mode = 2'd2;
    start_sweep(1'b0);
    wait_done(0, edges, hold_bad);
    e = sb.pop_front();
    vectors++; if (o_tt !== 16'hCC40) begin miscompares++; $display("[TB] FAIL fault9_tt: got %h, want cc40", o_tt); end
    vectors++; if ({o_mc, o_ffi, o_ffv} !== {e.mc, e.ffi, e.ffv}) begin miscompares++; $display("[TB] FAIL fault9_grade: got %0d/%0d/%b, want %0d/%0d/%b", o_mc, o_ffi, o_ffv, e.mc, e.ffi, e.ffv); end
    vectors++; if (o_pass !== 1'b0) begin miscompares++; $display("[TB] FAIL fault9_pass: got %b, want 0", o_pass); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int edges, hold_bad;
    sel0 = 1'b0; mode = 2'd1;
    start_sweep(1'b1);
    wait_done(0, edges, hold_bad);
    e = sb.pop_front();
    vectors++; if (edges != e.edges) begin miscompares++; $display("[TB] FAIL held_start_latency: got %0d, want %0d", edges, e.edges); end
    // start still high through the DONE edge: must land in IDLE with results intact
    @(negedge clk);
    vectors++; if ({o_busy, o_done, o_mc, o_tt} !== {1'b0, 1'b0, e.mc, e.tt}) begin miscompares++; $display("[TB] FAIL held_start_no_restart: got %h, want %h", {o_busy, o_done, o_mc, o_tt}, {1'b0, 1'b0, e.mc, e.tt}); end
    mode = 2'd0;
    sb.push_back(predict(mode, 2));
    @(posedge clk);
    #1 start2 = 1'b0;
    @(negedge clk);
    vectors++; if ({o_busy, o_vec, o_tt, o_mc, o_ffv, o_pass} !== {1'b1, 4'd0, 16'd0, 5'd0, 1'b0, 1'b0}) begin miscompares++; $display("[TB] FAIL restart_clears: got %h, want %h", {o_busy, o_vec, o_tt, o_mc, o_ffv, o_pass}, {1'b1, 4'd0, 16'd0, 5'd0, 1'b0, 1'b0}); end
    wait_done(1, edges, hold_bad);
    e = sb.pop_front();
    vectors++; if (edges != e.edges) begin miscompares++; $display("[TB] FAIL restart_latency: got %0d, want %0d", edges, e.edges); end
    vectors++; if ({o_pass, o_tt} !== {e.pass, e.tt}) begin miscompares++; $display("[TB] FAIL restart_result: got %b/%h, want %b/%h", o_pass, o_tt, e.pass, e.tt); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sweep();
    exp_t e;
    int edges, hold_bad, waited, bad_done;
    sel0 = 1'b0; mode = 2'd0;
    start_sweep(1'b0);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (o_vec != 4'd5 && waited < 100);
    vectors++; if (o_vec !== 4'd5) begin miscompares++; $display("[TB] FAIL midreset_reach_idx5: got %0d, want 5", o_vec); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_front());
    vectors++; if ({a2, b2, c2, d2, busy2, done2, pass2, tt2, mc2, ffi2, ffv2} !== 33'd0) begin miscompares++; $display("[TB] FAIL midreset_outputs: got %h, want 0", {a2, b2, c2, d2, busy2, done2, pass2, tt2, mc2, ffi2, ffv2}); end
    bad_done = 0;
    repeat (70) begin
      @(negedge clk);
      if (o_done || o_busy) bad_done++;
    end
    vectors++; if (bad_done != 0) begin miscompares++; $display("[TB] FAIL midreset_stays_idle: got %0d active cycles, want 0", bad_done); end
    start_sweep(1'b0);
    wait_done(0, edges, hold_bad);
    e = sb.pop_front();
    vectors++; if ({o_pass, o_tt, o_mc} !== {e.pass, e.tt, e.mc}) begin miscompares++; $display("[TB] FAIL midreset_fresh_sweep: got %b/%h/%0d, want %b/%h/%0d", o_pass, o_tt, o_mc, e.pass, e.tt, e.mc); end
    @(negedge clk);
  endtask

  task automatic test_settle_zero();
    exp_t e;
    int edges, hold_bad;
    sel0 = 1'b1; mode = 2'd0;
    start_sweep(1'b0);
    wait_done(0, edges, hold_bad);
    e = sb.pop_front();
    vectors++; if (edges != 32) begin miscompares++; $display("[TB] FAIL settle0_latency: got %0d, want 32", edges); end
    vectors++; if (hold_bad != 0) begin miscompares++; $display("[TB] FAIL settle0_vector_hold: got %0d bad, want 0", hold_bad); end
    vectors++; if ({o_pass, o_tt} !== {e.pass, e.tt}) begin miscompares++; $display("[TB] FAIL settle0_result: got %b/%h, want %b/%h", o_pass, o_tt, e.pass, e.tt); end
    @(negedge clk);
    sel0 = 1'b0;
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_golden();
    test_tied_zero();
    test_single_fault();
    test_back_to_back();
    test_reset_mid_sweep();
    test_settle_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
